// File: rtl/fp_wire.sv
// Shared types and constants for the FMA rounding pipeline.
package fp_wire;

   // Rounding-mode encodings carried in fp_rnd_in_type.rm
   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   // Format selector: 0 is single, anything else is treated as double
   localparam logic [1:0] FMT_SINGLE = 2'd0;
   localparam logic [1:0] FMT_DOUBLE = 2'd1;

   // Canonical quiet NaNs; the single one is already NaN-boxed
   localparam logic [63:0] NAN_SINGLE = 64'hFFFF_FFFF_7FC0_0000;
   localparam logic [63:0] NAN_DOUBLE = 64'h7FF8_0000_0000_0000;

   // Flag bit positions inside {NV,DZ,OF,UF,NX}
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // Unrounded result bundle produced by the FMA
   typedef struct packed {
      logic        sig;
      logic [13:0] expo;
      logic [53:0] mant;
      logic [1:0]  rema;
      logic [1:0]  fmt;
      logic [2:0]  rm;
      logic [2:0]  grs;
      logic        snan;
      logic        qnan;
      logic        dbz;
      logic        infs;
      logic        zero;
      logic        diff;
   } fp_rnd_in_type;

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  flags;
      logic        valid;
   } fp_rnd_pipe_out_type;

   // Stage 1: rounded (not yet renormalised) significand plus context
   typedef struct packed {
      logic        valid;
      logic        sig;
      logic [13:0] expo;
      logic [54:0] mant_rnd;
      logic        single;
      logic [2:0]  rm;
      logic [2:0]  grs;
      logic        snan;
      logic        qnan;
      logic        dbz;
      logic        infs;
      logic        zero;
      logic        diff;
   } fp_rnd_pipe_reg_type_1;

   // Stage 2: final packed result; result/flags are zero whenever valid is 0
   typedef struct packed {
      logic        valid;
      logic [63:0] result;
      logic [4:0]  flags;
   } fp_rnd_pipe_reg_type_2;

   localparam fp_rnd_pipe_reg_type_1 init_fp_rnd_pipe_reg_1 = '0;
   localparam fp_rnd_pipe_reg_type_2 init_fp_rnd_pipe_reg_2 = '0;

   // Signed infinity in the selected format
   function automatic logic [63:0] pack_inf(input logic sig, input logic single);
      if (single) return {32'hFFFF_FFFF, sig, 8'hFF, 23'h0};
      return {sig, 11'h7FF, 52'h0};
   endfunction

   // Largest finite magnitude in the selected format
   function automatic logic [63:0] pack_max(input logic sig, input logic single);
      if (single) return {32'hFFFF_FFFF, sig, 8'hFE, 23'h7F_FFFF};
      return {sig, 11'h7FE, 52'hF_FFFF_FFFF_FFFF};
   endfunction

   // Signed zero in the selected format
   function automatic logic [63:0] pack_zero(input logic sig, input logic single);
      if (single) return {32'hFFFF_FFFF, sig, 31'h0};
      return {sig, 63'h0};
   endfunction

endpackage

// File: rtl/fp_rnd_inc.sv
// Round-increment decision from sign, rounding mode, guard/round/sticky and LSB.
module fp_rnd_inc
   import fp_wire::*;
(
   input  logic       sig,
   input  logic [2:0] rm,
   input  logic [2:0] grs,
   input  logic       lsb,
   output logic       inc
);

   logic g;
   logic r;
   logic s;

   assign g = grs[2];
   assign r = grs[1];
   assign s = grs[0];

   // Select the increment rule for the rounding mode; unknown modes round to nearest even
   always_comb begin
      inc = 1'b0;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sig & (g | r | s);
         RM_RUP:  inc = ~sig & (g | r | s);
         RM_RMM:  inc = g;
         default: inc = g & (r | s | lsb);
      endcase
   end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage rounding pipeline: stage 1 rounds the significand, stage 2
// renormalises, handles overflow and special operands, packs and raises flags.
// Handshake: valid_i is accepted on a rising edge when stall=0 and flush=0;
// stall freezes both stages and the outputs; flush empties both stages and
// wins over stall and over an accepting valid_i; reset wins over everything.
module fp_rnd_pipe
   import fp_wire::*;
(
   input  logic          reset,
   input  logic          clock,
   input  logic          valid_i,
   input  logic          stall,
   input  logic          flush,
   input  fp_rnd_in_type fp_rnd_i,
   output logic [63:0]   result_o,
   output logic [4:0]    flags_o,
   output logic          valid_o
);

   fp_rnd_pipe_reg_type_1 r1;
   fp_rnd_pipe_reg_type_1 r1_d;
   fp_rnd_pipe_reg_type_2 r2;
   fp_rnd_pipe_reg_type_2 r2_d;
   fp_rnd_pipe_out_type   out;

   logic        inc;
   logic        carry;
   logic        hidden;
   logic [54:0] m_norm;
   logic [14:0] e_norm;
   logic [14:0] e_max;
   logic        nx;
   logic        uf;
   logic        ovf;
   logic        to_max;
   logic        zero_sig;
   logic        unused_bits;

   fp_rnd_inc u_inc (
      .sig (fp_rnd_i.sig),
      .rm  (fp_rnd_i.rm),
      .grs (fp_rnd_i.grs),
      .lsb (fp_rnd_i.mant[0]),
      .inc (inc)
   );

   // Stage 1: apply the increment; the extra top bit catches a double carry-out
   always_comb begin
      r1_d = init_fp_rnd_pipe_reg_1;
      if (valid_i) begin
         r1_d.valid    = 1'b1;
         r1_d.sig      = fp_rnd_i.sig;
         r1_d.expo     = fp_rnd_i.expo;
         r1_d.mant_rnd = {1'b0, fp_rnd_i.mant} + {54'b0, inc};
         r1_d.single   = (fp_rnd_i.fmt == FMT_SINGLE);
         r1_d.rm       = fp_rnd_i.rm;
         r1_d.grs      = fp_rnd_i.grs;
         r1_d.snan     = fp_rnd_i.snan;
         r1_d.qnan     = fp_rnd_i.qnan;
         r1_d.dbz      = fp_rnd_i.dbz;
         r1_d.infs     = fp_rnd_i.infs;
         r1_d.zero     = fp_rnd_i.zero;
         r1_d.diff     = fp_rnd_i.diff;
      end
   end

   // Stage 2 datapath: renormalise after carry, detect overflow, derive flags
   always_comb begin
      carry  = r1.single ? r1.mant_rnd[24] : r1.mant_rnd[53];
      m_norm = carry ? (r1.mant_rnd >> 1) : r1.mant_rnd;
      e_norm = {1'b0, r1.expo} + {14'b0, carry};
      hidden = r1.single ? m_norm[23] : m_norm[52];
      // A subnormal that rounded up into the hidden bit becomes the smallest normal
      if (e_norm == 15'd0 && hidden) begin
         e_norm = 15'd1;
      end
      e_max    = r1.single ? 15'd255 : 15'd2047;
      ovf      = (e_norm >= e_max);
      nx       = |r1.grs;
      uf       = nx & (r1.expo == 14'd0);
      to_max   = (r1.rm == RM_RTZ) || (r1.rm == RM_RDN && !r1.sig) ||
                 (r1.rm == RM_RUP && r1.sig);
      zero_sig = (r1.zero && r1.diff) ? (r1.rm == RM_RDN) : r1.sig;
   end

   // Stage 2 result selection in special-case priority order
   always_comb begin
      r2_d = init_fp_rnd_pipe_reg_2;
      if (r1.valid) begin
         r2_d.valid = 1'b1;
         if (r1.snan) begin
            r2_d.result          = r1.single ? NAN_SINGLE : NAN_DOUBLE;
            r2_d.flags[FLAG_NV]  = 1'b1;
         end else if (r1.qnan) begin
            r2_d.result          = r1.single ? NAN_SINGLE : NAN_DOUBLE;
         end else if (r1.dbz) begin
            r2_d.result          = pack_inf(r1.sig, r1.single);
            r2_d.flags[FLAG_DZ]  = 1'b1;
         end else if (r1.infs) begin
            r2_d.result          = pack_inf(r1.sig, r1.single);
         end else if (r1.zero) begin
            r2_d.result          = pack_zero(zero_sig, r1.single);
         end else if (ovf) begin
            r2_d.result          = to_max ? pack_max(r1.sig, r1.single)
                                          : pack_inf(r1.sig, r1.single);
            r2_d.flags[FLAG_OF]  = 1'b1;
            r2_d.flags[FLAG_UF]  = uf;
            r2_d.flags[FLAG_NX]  = 1'b1;
         end else begin
            if (r1.single) begin
               r2_d.result = {32'hFFFF_FFFF, r1.sig, e_norm[7:0], m_norm[22:0]};
            end else begin
               r2_d.result = {r1.sig, e_norm[10:0], m_norm[51:0]};
            end
            r2_d.flags[FLAG_UF] = uf;
            r2_d.flags[FLAG_NX] = nx;
         end
      end
   end

   // Pipeline registers: reset, then flush, then stall hold, else advance
   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         r1 <= init_fp_rnd_pipe_reg_1;
         r2 <= init_fp_rnd_pipe_reg_2;
      end else if (!stall) begin
         r1 <= r1_d;
         r2 <= r2_d;
      end
   end

   assign out.result = r2.result;
   assign out.flags  = r2.flags;
   assign out.valid  = r2.valid;

   assign result_o = out.result;
   assign flags_o  = out.flags;
   assign valid_o  = out.valid;

   // Remainder bits and the top of the renormalised significand are not packed
   assign unused_bits = ^{fp_rnd_i.rema, m_norm};

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Directed bench for fp_rnd_pipe with hand-computed expected results.
module tb_fp_rnd_pipe;
   import fp_wire::*;

   logic          reset;
   logic          clock;
   logic          valid_i;
   logic          stall;
   logic          flush;
   fp_rnd_in_type fp_rnd_i;
   logic [63:0]   result_o;
   logic [4:0]    flags_o;
   logic          valid_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] exp_q[$];

   fp_rnd_pipe dut (
      .reset    (reset),
      .clock    (clock),
      .valid_i  (valid_i),
      .stall    (stall),
      .flush    (flush),
      .fp_rnd_i (fp_rnd_i),
      .result_o (result_o),
      .flags_o  (flags_o),
      .valid_o  (valid_o)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic fp_rnd_in_type mk(input logic sig, input logic [13:0] expo,
                                        input logic [53:0] mant, input logic [1:0] fmt,
                                        input logic [2:0] rm, input logic [2:0] grs);
      fp_rnd_in_type v;
      v      = '0;
      v.sig  = sig;
      v.expo = expo;
      v.mant = mant;
      v.fmt  = fmt;
      v.rm   = rm;
      v.grs  = grs;
      return v;
   endfunction

   // Single transaction: checks 2-cycle latency, result, and optionally flags
   task automatic run_vec(input string tag, input fp_rnd_in_type v,
                          input logic [63:0] exp_res, input logic [4:0] exp_flags,
                          input logic chk_flags);
      fp_rnd_i = v;
      valid_i  = 1'b1;
      step();
      valid_i  = 1'b0;
      check({tag, "_lat1"}, {63'b0, valid_o}, 64'd0);
      step();
      check({tag, "_valid"}, {63'b0, valid_o}, 64'd1);
      check({tag, "_res"}, result_o, exp_res);
      if (chk_flags) check({tag, "_flags"}, {59'b0, flags_o}, {59'b0, exp_flags});
      step();
   endtask

   fp_rnd_in_type v;
   fp_rnd_in_type stream [4];
   logic [63:0]   stream_exp [4];

   initial begin
      reset    = 1'b0;
      valid_i  = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      fp_rnd_i = '0;

      // Reset state
      step();
      step();
      check("rst_valid", {63'b0, valid_o}, 64'd0);
      check("rst_res", result_o, 64'd0);
      check("rst_flags", {59'b0, flags_o}, 64'd0);
      reset = 1'b1;
      step();

      // Rounding, carry, subnormal and overflow cases
      run_vec("one_s", mk(0, 14'd127, 54'h80_0000, FMT_SINGLE, RM_RNE, 3'b000),
              64'hFFFF_FFFF_3F80_0000, 5'h00, 1);
      run_vec("tie_odd", mk(0, 14'd127, 54'h80_0001, FMT_SINGLE, RM_RNE, 3'b100),
              64'hFFFF_FFFF_3F80_0002, 5'h01, 1);
      run_vec("tie_even", mk(0, 14'd127, 54'h80_0000, FMT_SINGLE, RM_RNE, 3'b100),
              64'hFFFF_FFFF_3F80_0000, 5'h01, 1);
      run_vec("rup_pos", mk(0, 14'd127, 54'h80_0000, FMT_SINGLE, RM_RUP, 3'b001),
              64'hFFFF_FFFF_3F80_0001, 5'h01, 1);
      run_vec("rdn_pos", mk(0, 14'd127, 54'h80_0000, FMT_SINGLE, RM_RDN, 3'b011),
              64'hFFFF_FFFF_3F80_0000, 5'h01, 1);
      run_vec("rmm", mk(1, 14'd127, 54'h80_0000, FMT_SINGLE, RM_RMM, 3'b100),
              64'hFFFF_FFFF_BF80_0001, 5'h01, 1);
      run_vec("carry_s", mk(0, 14'd127, 54'hFF_FFFF, FMT_SINGLE, RM_RNE, 3'b100),
              64'hFFFF_FFFF_4000_0000, 5'h01, 1);
      run_vec("sub2norm", mk(0, 14'd0, 54'h7F_FFFF, FMT_SINGLE, RM_RNE, 3'b100),
              64'hFFFF_FFFF_0080_0000, 5'h03, 1);
      run_vec("ovf_rne", mk(0, 14'd2046, 54'h1F_FFFF_FFFF_FFFF, FMT_DOUBLE, RM_RNE, 3'b100),
              64'h7FF0_0000_0000_0000, 5'h05, 1);
      // Largest finite value truncated without rounding up
      run_vec("rtz_2046", mk(0, 14'd2046, 54'h1F_FFFF_FFFF_FFFF, FMT_DOUBLE, RM_RTZ, 3'b100),
              64'h7FEF_FFFF_FFFF_FFFF, 5'h00, 0);
      run_vec("ovf_rtz", mk(0, 14'd2047, 54'h1F_FFFF_FFFF_FFFF, FMT_DOUBLE, RM_RTZ, 3'b100),
              64'h7FEF_FFFF_FFFF_FFFF, 5'h05, 1);
      run_vec("ovf_rup_neg", mk(1, 14'd2047, 54'h1F_FFFF_FFFF_FFFF, FMT_DOUBLE, RM_RUP, 3'b100),
              64'hFFEF_FFFF_FFFF_FFFF, 5'h05, 1);

      // Special operands
      v = mk(0, 14'd5, 54'h1, FMT_DOUBLE, RM_RNE, 3'b111); v.snan = 1'b1;
      run_vec("snan_d", v, 64'h7FF8_0000_0000_0000, 5'h10, 1);
      v = mk(0, 14'd5, 54'h1, FMT_SINGLE, RM_RNE, 3'b000); v.qnan = 1'b1;
      run_vec("qnan_s", v, 64'hFFFF_FFFF_7FC0_0000, 5'h00, 1);
      v = mk(1, 14'd0, 54'h0, FMT_SINGLE, RM_RNE, 3'b000); v.dbz = 1'b1;
      run_vec("dbz_s", v, 64'hFFFF_FFFF_FF80_0000, 5'h08, 1);
      v = mk(0, 14'd0, 54'h0, FMT_DOUBLE, RM_RNE, 3'b000); v.infs = 1'b1;
      run_vec("inf_d", v, 64'h7FF0_0000_0000_0000, 5'h00, 1);
      v = mk(0, 14'd0, 54'h0, FMT_DOUBLE, RM_RDN, 3'b000); v.zero = 1'b1; v.diff = 1'b1;
      run_vec("zero_rdn", v, 64'h8000_0000_0000_0000, 5'h00, 1);
      v = mk(1, 14'd0, 54'h0, FMT_SINGLE, RM_RNE, 3'b000); v.zero = 1'b1;
      run_vec("zero_neg_s", v, 64'hFFFF_FFFF_8000_0000, 5'h00, 1);

      // Back-to-back stream with a 3-cycle stall in the middle
      for (int k = 0; k < 4; k++) begin
         stream[k]     = mk(0, 14'd127, 54'h80_0000 + 54'(k + 1), FMT_SINGLE, RM_RNE, 3'b000);
         stream_exp[k] = 64'hFFFF_FFFF_3F80_0000 + 64'(k + 1);
      end
      begin
         logic [11:0] stall_pat;
         logic [63:0] last_exp;
         int idx;
         int seen;
         stall_pat = 12'h01C;
         last_exp  = '0;
         idx       = 0;
         seen      = 0;
         for (int c = 0; c < 12; c++) begin
            stall   = stall_pat[c];
            valid_i = (idx < 4);
            if (idx < 4) fp_rnd_i = stream[idx];
            step();
            if (!stall_pat[c] && idx < 4) begin
               exp_q.push_back(stream_exp[idx]);
               idx++;
            end
            if (stall_pat[c]) begin
               if (seen > 0) begin
                  check("stall_valid", {63'b0, valid_o}, 64'd1);
                  check("stall_hold", result_o, last_exp);
               end
            end else if (valid_o) begin
               if (exp_q.size() > 0) begin
                  last_exp = exp_q.pop_front();
                  check("stream_res", result_o, last_exp);
                  check("stream_flags", {59'b0, flags_o}, 64'd0);
                  seen++;
               end else begin
                  check("stream_extra", {63'b0, valid_o}, 64'd0);
               end
            end
         end
         check("stream_count", 64'(seen), 64'd4);
         check("stream_drain", 64'(exp_q.size()), 64'd0);
      end
      valid_i = 1'b0;
      stall   = 1'b0;

      // Flush together with stall and a new valid_i empties the pipe
      fp_rnd_i = stream[0];
      valid_i  = 1'b1;
      step();
      fp_rnd_i = stream[1];
      stall    = 1'b1;
      flush    = 1'b1;
      step();
      stall    = 1'b0;
      flush    = 1'b0;
      valid_i  = 1'b0;
      check("flush_valid", {63'b0, valid_o}, 64'd0);
      check("flush_res", result_o, 64'd0);
      step();
      check("flush_valid2", {63'b0, valid_o}, 64'd0);
      step();
      check("flush_valid3", {63'b0, valid_o}, 64'd0);

      // Reset with a result in flight, held together with stall
      fp_rnd_i = stream[2];
      valid_i  = 1'b1;
      step();
      valid_i  = 1'b0;
      reset    = 1'b0;
      stall    = 1'b1;
      step();
      reset    = 1'b1;
      stall    = 1'b0;
      check("rst_fl_valid", {63'b0, valid_o}, 64'd0);
      step();
      check("rst_fl_valid2", {63'b0, valid_o}, 64'd0);
      step();
      check("rst_fl_valid3", {63'b0, valid_o}, 64'd0);
      check("rst_fl_flags", {59'b0, flags_o}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
